// File: rtl/hid_pkg.sv
// Shared constants, types and helpers for the HID boot-keyboard event path.
package hid_pkg;

    localparam logic [7:0]  KEY_NONE         = 8'h00;
    localparam logic [7:0]  KEY_ERR_ROLLOVER = 8'h01;
    localparam int unsigned REPORT_LEN       = 8;
    localparam int unsigned KEY_SLOTS        = 6;

    typedef logic [KEY_SLOTS-1:0][7:0] key_slots_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_EMIT
    } state_e;

    function automatic logic slots_contain(input key_slots_t slots, input logic [7:0] key);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < KEY_SLOTS; i++) begin
            if (slots[i] == key) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/hid_key_event_if.sv
// Report byte stream in, key events out; slave is the event generator's view.
interface hid_key_event_if;

    logic [7:0] i_rx_byte;
    logic       i_rx_valid;
    logic       i_rx_sof;
    logic [7:0] o_key;
    logic [7:0] o_mod;
    logic       o_valid;
    logic       i_ready;
    logic       o_overrun;

    modport slave (
        input  i_rx_byte, i_rx_valid, i_rx_sof, i_ready,
        output o_key, o_mod, o_valid, o_overrun
    );

    modport master (
        output i_rx_byte, i_rx_valid, i_rx_sof, i_ready,
        input  o_key, o_mod, o_valid, o_overrun
    );

endinterface

// File: rtl/hid_report_capture.sv
// Assembles 8-byte boot reports, drops rollover reports and holds the latest
// complete report in a single pending slot that is never back-pressured.
module hid_report_capture
    import hid_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_valid_i,
    input  logic       rx_sof_i,
    input  logic       pend_clr_i,
    output logic       pend_valid_o,
    output logic [7:0] pend_mod_o,
    output key_slots_t pend_keys_o,
    output logic       overrun_o
);

    localparam logic [3:0] IDX_DONE = 4'(REPORT_LEN);
    localparam logic [3:0] IDX_LAST = 4'(REPORT_LEN - 1);

    logic [3:0] idx_q, idx_d;
    logic [7:0] asm_mod_q, asm_mod_d;
    key_slots_t asm_keys_q, asm_keys_d;
    logic [7:0] pend_mod_q, pend_mod_d;
    key_slots_t pend_keys_q, pend_keys_d;
    logic       pend_valid_q, pend_valid_d;
    logic       overrun_q, overrun_d;

    logic [2:0] slot;
    logic       complete;

    always_comb begin
        idx_d        = idx_q;
        asm_mod_d    = asm_mod_q;
        asm_keys_d   = asm_keys_q;
        pend_mod_d   = pend_mod_q;
        pend_keys_d  = pend_keys_q;
        pend_valid_d = pend_valid_q & ~pend_clr_i;
        overrun_d    = 1'b0;
        complete     = 1'b0;
        slot         = 3'(idx_q - 4'd2);

        if (rx_valid_i) begin
            if (rx_sof_i) begin
                asm_mod_d = rx_byte_i;
                idx_d     = 4'd1;
            end else if (idx_q < IDX_DONE) begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd0) begin
                    asm_mod_d = rx_byte_i;
                end else if (idx_q >= 4'd2) begin
                    asm_keys_d[slot] = rx_byte_i;
                end
                complete = (idx_q == IDX_LAST);
            end
        end

        // Overwrite only counts when the parent is not taking the old report this cycle.
        if (complete && !slots_contain(asm_keys_d, KEY_ERR_ROLLOVER)) begin
            pend_mod_d   = asm_mod_d;
            pend_keys_d  = asm_keys_d;
            pend_valid_d = 1'b1;
            overrun_d    = pend_valid_q & ~pend_clr_i;
        end
    end

    // Index parks at REPORT_LEN so stray bytes are ignored until the first sof.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q        <= IDX_DONE;
            asm_mod_q    <= '0;
            asm_keys_q   <= '0;
            pend_mod_q   <= '0;
            pend_keys_q  <= '0;
            pend_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            asm_mod_q    <= asm_mod_d;
            asm_keys_q   <= asm_keys_d;
            pend_mod_q   <= pend_mod_d;
            pend_keys_q  <= pend_keys_d;
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_mod_o   = pend_mod_q;
    assign pend_keys_o  = pend_keys_q;
    assign overrun_o    = overrun_q;

endmodule

// File: rtl/hid_key_event.sv
// Turns HID boot keyboard reports into one-per-handshake key-press events,
// with typematic auto-repeat of the most recently pressed key.
module hid_key_event
    import hid_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 6_000_000,
    parameter int unsigned REPEAT_RATE  = 1_200_000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    hid_key_event_if.slave bus
);

    localparam int unsigned      TMR_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned      TMR_W     = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] TMR_DELAY = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0] TMR_RATE  = TMR_W'(REPEAT_RATE);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [2:0]       LAST_SLOT = 3'(KEY_SLOTS - 1);

    logic       pend_valid;
    logic [7:0] pend_mod;
    key_slots_t pend_keys;
    logic       pend_clr;
    logic       overrun;

    hid_report_capture u_capture (
        .clk_i        (i_clk),
        .rst_ni       (i_rst_n),
        .rx_byte_i    (bus.i_rx_byte),
        .rx_valid_i   (bus.i_rx_valid),
        .rx_sof_i     (bus.i_rx_sof),
        .pend_clr_i   (pend_clr),
        .pend_valid_o (pend_valid),
        .pend_mod_o   (pend_mod),
        .pend_keys_o  (pend_keys),
        .overrun_o    (overrun)
    );

    state_e           state_q, state_d;
    logic [2:0]       slot_q, slot_d;
    logic             rep_emit_q, rep_emit_d;
    logic [7:0]       cur_mod_q, cur_mod_d;
    key_slots_t       cur_keys_q, cur_keys_d;
    logic [7:0]       prev_mod_q, prev_mod_d;
    key_slots_t       prev_keys_q, prev_keys_d;
    logic [7:0]       rep_key_q, rep_key_d;
    logic             rep_active_q, rep_active_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       key_q, key_d;
    logic [7:0]       mod_q, mod_d;

    logic [7:0] cur_key;
    logic       is_new;
    logic       commit;

    assign cur_key = cur_keys_q[slot_q];
    assign is_new  = (cur_key != KEY_NONE) && !slots_contain(prev_keys_q, cur_key);

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        rep_emit_d   = rep_emit_q;
        cur_mod_d    = cur_mod_q;
        cur_keys_d   = cur_keys_q;
        prev_mod_d   = prev_mod_q;
        prev_keys_d  = prev_keys_q;
        rep_key_d    = rep_key_q;
        rep_active_d = rep_active_q;
        timer_d      = timer_q;
        key_d        = key_q;
        mod_d        = mod_q;
        pend_clr     = 1'b0;
        commit       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (timer_q != '0) timer_d = timer_q - TMR_ONE;
                if (pend_valid) begin
                    pend_clr   = 1'b1;
                    cur_mod_d  = pend_mod;
                    cur_keys_d = pend_keys;
                    slot_d     = '0;
                    state_d    = ST_COMPARE;
                end else if (rep_active_q && timer_q == '0) begin
                    key_d      = rep_key_q;
                    mod_d      = prev_mod_q;
                    rep_emit_d = 1'b1;
                    state_d    = ST_EMIT;
                end
            end
            ST_COMPARE: begin
                if (is_new) begin
                    key_d      = cur_key;
                    mod_d      = cur_mod_q;
                    rep_emit_d = 1'b0;
                    state_d    = ST_EMIT;
                end else if (slot_q == LAST_SLOT) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            ST_EMIT: begin
                if (bus.i_ready) begin
                    if (rep_emit_q) begin
                        timer_d = TMR_RATE;
                        state_d = ST_IDLE;
                    end else begin
                        rep_key_d    = key_q;
                        rep_active_d = 1'b1;
                        timer_d      = TMR_DELAY;
                        if (slot_q == LAST_SLOT) begin
                            commit  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            slot_d  = slot_q + 3'd1;
                            state_d = ST_COMPARE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A slot-5 press commits in the same cycle it becomes the repeat key.
        if (commit) begin
            prev_mod_d  = cur_mod_q;
            prev_keys_d = cur_keys_q;
            if (!slots_contain(cur_keys_q, rep_key_d)) rep_active_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            rep_emit_q   <= 1'b0;
            cur_mod_q    <= '0;
            cur_keys_q   <= '0;
            prev_mod_q   <= '0;
            prev_keys_q  <= '0;
            rep_key_q    <= '0;
            rep_active_q <= 1'b0;
            timer_q      <= '0;
            key_q        <= '0;
            mod_q        <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            rep_emit_q   <= rep_emit_d;
            cur_mod_q    <= cur_mod_d;
            cur_keys_q   <= cur_keys_d;
            prev_mod_q   <= prev_mod_d;
            prev_keys_q  <= prev_keys_d;
            rep_key_q    <= rep_key_d;
            rep_active_q <= rep_active_d;
            timer_q      <= timer_d;
            key_q        <= key_d;
            mod_q        <= mod_d;
        end
    end

    assign bus.o_valid   = (state_q == ST_EMIT);
    assign bus.o_key     = key_q;
    assign bus.o_mod     = mod_q;
    assign bus.o_overrun = overrun;

endmodule

// File: tb/tb_hid_key_event.sv
// Directed bench for hid_key_event: a report/event table plus hand sequences
// for backpressure, overrun, typematic timing and reset during an event.
module tb_hid_key_event;

    logic clk;
    logic rst_n;

    hid_key_event_if bus ();

    hid_key_event #(
        .REPEAT_DELAY (20),
        .REPEAT_RATE  (5)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rpt;
        int          n_ev;
        logic [47:0] keys;
        logic [7:0]  mod;
        int          lat;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    int nvec = 0;
    int nerr = 0;

    logic [7:0] ev_key [$];
    logic [7:0] ev_mod [$];
    int         ev_cyc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        bus.i_rx_sof   = 1'b0;
    endtask

    task automatic send_report(input logic [63:0] r, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            bus.i_rx_valid = 1'b1;
            bus.i_rx_sof   = (i == 0);
            bus.i_rx_byte  = r[63 - 8*i -: 8];
        end
    endtask

    // Records every event seen with i_ready high; cycle 0 is the first negedge
    // after the last report byte was clocked in.
    task automatic collect(input int ncyc);
        ev_key.delete();
        ev_mod.delete();
        ev_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            idle_cycle();
            if (bus.o_valid === 1'b1) begin
                ev_key.push_back(bus.o_key);
                ev_mod.push_back(bus.o_mod);
                ev_cyc.push_back(c);
            end
        end
    endtask

    task automatic check_events(input string tag, input int n, input logic [47:0] keys,
                                input logic [7:0] mod, input int lat);
        chk({tag, " count"}, ev_key.size(), n);
        for (int k = 0; k < n && k < ev_key.size(); k++) begin
            chk($sformatf("%s key%0d", tag, k), ev_key[k], keys[47 - 8*k -: 8]);
            chk($sformatf("%s mod%0d", tag, k), ev_mod[k], mod);
        end
        if (n > 0 && ev_cyc.size() > 0) chk({tag, " latency"}, ev_cyc[0], lat);
    endtask

    initial begin
        int exp_cyc [4];

        tbl[0]  = '{64'h0000_0400_0000_0000, 1, 48'h04_00_00_00_00_00, 8'h00, 2};
        tbl[1]  = '{64'h0000_0000_0000_0000, 0, 48'h0,                 8'h00, 0};
        tbl[2]  = '{64'h0000_0400_0000_0000, 1, 48'h04_00_00_00_00_00, 8'h00, 2};
        tbl[3]  = '{64'h0000_0405_0000_0000, 1, 48'h05_00_00_00_00_00, 8'h00, 3};
        tbl[4]  = '{64'h0000_0400_0000_0000, 0, 48'h0,                 8'h00, 0};
        tbl[5]  = '{64'h0000_0101_0101_0101, 0, 48'h0,                 8'h00, 0};
        tbl[6]  = '{64'h0000_0400_0000_0000, 0, 48'h0,                 8'h00, 0};
        tbl[7]  = '{64'h0200_0400_0000_0000, 0, 48'h0,                 8'h00, 0};
        tbl[8]  = '{64'h2200_0000_0000_0007, 1, 48'h07_00_00_00_00_00, 8'h22, 7};
        tbl[9]  = '{64'h0000_0000_0000_0000, 0, 48'h0,                 8'h00, 0};
        tbl[10] = '{64'h0100_0a0b_0c0d_0e0f, 6, 48'h0a_0b_0c_0d_0e_0f, 8'h01, 2};
        tbl[11] = '{64'h0000_0000_0000_0000, 0, 48'h0,                 8'h00, 0};

        bus.i_rx_byte  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_sof   = 1'b0;
        bus.i_ready    = 1'b1;
        rst_n          = 1'b0;

        repeat (3) idle_cycle();
        chk("reset o_key",     bus.o_key,     8'h00);
        chk("reset o_mod",     bus.o_mod,     8'h00);
        chk("reset o_valid",   bus.o_valid,   1'b0);
        chk("reset o_overrun", bus.o_overrun, 1'b0);
        rst_n = 1'b1;
        idle_cycle();

        for (int v = 0; v < NV; v++) begin
            send_report(tbl[v].rpt, 8);
            collect(14);
            check_events($sformatf("vec%0d", v), tbl[v].n_ev, tbl[v].keys, tbl[v].mod, tbl[v].lat);
        end

        // Cut-short report followed by an empty report: nothing may be emitted.
        send_report(64'h0000_0900_0000_0000, 5);
        send_report(64'h0, 8);
        collect(14);
        check_events("short", 0, 48'h0, 8'h00, 0);

        // Backpressure: first event held for 10 cycles, then the second key.
        bus.i_ready = 1'b0;
        send_report(64'h0200_0405_0000_0000, 8);
        repeat (2) idle_cycle();
        for (int c = 0; c < 10; c++) begin
            idle_cycle();
            chk($sformatf("bp hold c%0d", c), {bus.o_valid, bus.o_key, bus.o_mod}, {1'b1, 8'h04, 8'h02});
        end
        bus.i_ready = 1'b1;
        collect(6);
        check_events("bp second", 1, 48'h05_00_00_00_00_00, 8'h02, 1);
        send_report(64'h0, 8);
        collect(14);
        check_events("bp release", 0, 48'h0, 8'h00, 0);

        // Overrun: FSM stalled on A, B pends, C overwrites B.
        bus.i_ready = 1'b0;
        send_report(64'h0000_0a00_0000_0000, 8);
        send_report(64'h0000_0a0b_0000_0000, 8);
        idle_cycle();
        chk("ovr after B", bus.o_overrun, 1'b0);
        send_report(64'h0000_0a0c_0000_0000, 8);
        idle_cycle();
        chk("ovr pulse", bus.o_overrun, 1'b1);
        chk("ovr stalled event", {bus.o_valid, bus.o_key}, {1'b1, 8'h0a});
        idle_cycle();
        chk("ovr pulse end", bus.o_overrun, 1'b0);
        bus.i_ready = 1'b1;
        collect(16);
        check_events("ovr C", 1, 48'h0c_00_00_00_00_00, 8'h00, 8);
        send_report(64'h0, 8);
        collect(14);
        check_events("ovr release", 0, 48'h0, 8'h00, 0);

        // Typematic: key in slot 5 so the FSM is back in IDLE right after the press.
        send_report(64'h0200_0000_0000_0004, 8);
        collect(50);
        exp_cyc = '{7, 29, 36, 43};
        chk("rep count", ev_key.size(), 4);
        for (int k = 0; k < 4 && k < ev_key.size(); k++) begin
            chk($sformatf("rep cyc%0d", k), ev_cyc[k], exp_cyc[k]);
            chk($sformatf("rep key%0d", k), ev_key[k], 8'h04);
            chk($sformatf("rep mod%0d", k), ev_mod[k], 8'h02);
        end
        send_report(64'h0, 8);
        collect(40);
        check_events("rep release", 0, 48'h0, 8'h00, 0);

        // Reset while an event is presented.
        bus.i_ready = 1'b0;
        send_report(64'h0000_0400_0000_0000, 8);
        repeat (2) idle_cycle();
        idle_cycle();
        chk("rst pre valid", bus.o_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async outs", {bus.o_valid, bus.o_key, bus.o_mod, bus.o_overrun}, {1'b0, 8'h00, 8'h00, 1'b0});
        repeat (2) idle_cycle();
        rst_n       = 1'b1;
        bus.i_ready = 1'b1;
        send_report(64'h0000_0400_0000_0000, 8);
        collect(14);
        check_events("rst resend", 1, 48'h04_00_00_00_00_00, 8'h00, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hid_key_event.md
# hid_key_event

Converts the byte stream of USB HID boot-protocol keyboard reports into discrete key-press events, one scan code per handshake, with typematic auto-repeat. Sits directly upstream of the scan-code-to-character mapper: `o_key`/`o_mod` drive its scan-code and modifier inputs. `o_valid`/`i_ready` pace the terminal input path.

## Interface

Parameters:
- `REPEAT_DELAY`, default 6_000_000: cycles from a press event to the first repeat (500 ms at 12 MHz).
- `REPEAT_RATE`, default 1_200_000: cycles between subsequent repeats (100 ms at 12 MHz).

Ports:
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_rx_byte`  in  8  report byte.
- `i_rx_valid`  in  1  `i_rx_byte` is valid this cycle.
- `i_rx_sof`  in  1  qualifies a valid byte as byte 0 of a report.
- `o_key`  out  8  HID usage code of the event.
- `o_mod`  out  8  modifier byte paired with `o_key`.
- `o_valid`  out  1  event available.
- `i_ready`  in  1  consumer accepts the event.
- `o_overrun`  out  1  one-cycle pulse when a pending report is overwritten.

## Operation

- **Report format:** byte 0 is the modifier, byte 1 is reserved (ignored), bytes 2–7 are key slots 0–5.
- **Capture:**
  - A valid byte with `i_rx_sof` sets the index to 0; otherwise the index increments.
  - Bytes beyond index 7 are ignored until the next sof.
  - A report is complete when byte 7 is accepted. A report cut short by a new sof is discarded.
- **Rollover:** a complete report with any slot equal to 0x01 (ErrorRollOver) is discarded. The previous report and repeat state are unchanged.
- **Pending buffer:**
  - A complete report goes to the pending buffer.
  - If the pending buffer is already full, the new report overwrites it and `o_overrun` pulses.
  - Capture never stalls.
- **FSM states:**
  - IDLE
    - A pending report moves the FSM to COMPARE with slot 0 and clears the pending flag.
    - Otherwise, if repeat is active and the timer is 0, go to EMIT with the repeat key.
  - COMPARE
    - Evaluates one slot per cycle.
    - A slot is new if it is nonzero and matches none of the 6 previous-report slots (parallel compare). A new slot goes to EMIT.
    - After slot 5: copy the current report to the previous report and return to IDLE.
  - EMIT
    - `o_valid`=1, with `o_key`/`o_mod` (the current report's modifier) held stable.
    - On `o_valid && i_ready`: return to COMPARE at the next slot, or to IDLE after a repeat emit or when slot 5 was emitted.
- **Repeat:**
  - Each new key emitted becomes the repeat key; the timer loads `REPEAT_DELAY` and repeat is active.
  - When a report is committed without the repeat key in any slot, repeat is cancelled.
  - A repeat emit reloads the timer with `REPEAT_RATE` on handshake, using the last committed modifier.
  - The timer decrements only in IDLE and saturates at 0.
  - A pending report has priority over a due repeat.
- **Modifier-only changes** produce no event.

## Timing

- **Reset values:** `o_key`=0, `o_mod`=0, `o_valid`=0, `o_overrun`=0. Reset also clears the previous report, the pending flag, the index, repeat and the timer.
- **Reset mid-operation:** all outputs drop asynchronously. The next report is treated entirely as new.
- **Latency:** byte 7 accepted at edge E with the FSM in IDLE and the first new key in slot s gives `o_valid` high after edge E+2+s.
- **Handshake:** transfer occurs at an edge where `o_valid && i_ready`. `o_valid` falls after that edge unless the next slot is immediately new (then `o_valid` is high again 2 edges later).
- **Event spacing:** no combinational path from `i_ready` to `o_valid`. The maximum event rate is one per 2 cycles.
- **Repeat timing:** the first repeat `o_valid` rises `REPEAT_DELAY`+1 cycles after the press handshake, provided the FSM stays in IDLE.

## Structure

- Package `hid_pkg`:
  - `KEY_NONE`=8'h00, `KEY_ERR_ROLLOVER`=8'h01.
  - `REPORT_LEN`=8, `KEY_SLOTS`=6.
  - FSM state typedef.
- Sub-module `hid_report_capture`: byte index, assembly buffer, rollover check, pending buffer and overrun pulse. It presents a pending report (modifier plus 6 slots) and a pending flag, cleared by the parent.
- Timer width is `$clog2` of the larger of `REPEAT_DELAY` and `REPEAT_RATE`, plus 1.

## Test plan

Benches use `REPEAT_DELAY`=20 and `REPEAT_RATE`=5 unless stated.

- **Single press:** report {00,00,04,0,0,0,0,0} → one event `o_key`=04, `o_mod`=00, `o_valid` at E+2. Then an all-zero report → no event.
- **Two new keys with backpressure:** report {02,00,04,05,0,…} with `i_ready` low for 10 cycles → `o_key`=04/`o_mod`=02 held stable for all 10 cycles, then event 05.
- **Held key:** previous {04}, new {04,05} → only 05 emitted. A short report (sof after 5 bytes) → discarded, no event.
- **Rollover:** report with all slots = 01 → no event and previous report retained. A following {04} report is still compared against the pre-rollover previous report.
- **Typematic:** hold 04 with `i_ready`=1 → event at press, repeat 21 cycles after the handshake, then every 6 cycles. A release report → no further repeats.
- **Reset mid-emit:** assert `i_rst_n`=0 while `o_valid`=1 → `o_valid`=0 immediately. After release, re-sending {04} → event 04.
